// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: groups the pipeline-side observation signals and the
// stall/flush controls that the hazard controller drives back into the pipe.
//   slave  : controller side (observes pipeline state, drives enables/flushes)
//   master : pipeline/bench side (drives pipeline state, observes controls)
// Signals:
//   id_rs, id_rt           ID source registers
//   idex_mem_read, idex_rt load sitting in ID/EX and its destination
//   exmem_*                branch/jump/memory info registered in EX/MEM
//   dmem_ready             data memory completes this cycle
//   perf_clear             synchronous clear of the perf counters
//   *_write, *_flush       pipeline register enables and bubble strobes
//   memwb_bubble, redirect bubble into MEM/WB, PC target select
//   mem_timeout            sticky memory fault flag
//   stall_cycles, flush_count  saturating perf counters
interface pipeline_hazard_controller_if #(
  parameter int COUNT_W = 16
);
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               idex_mem_read;
  logic [4:0]         idex_rt;
  logic               exmem_zero;
  logic               exmem_branch_eq;
  logic               exmem_branch_ne;
  logic               exmem_jump;
  logic               exmem_mem_access;
  logic               dmem_ready;
  logic               perf_clear;
  logic               pc_write;
  logic               ifid_write;
  logic               idex_write;
  logic               exmem_write;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_flush;
  logic               memwb_bubble;
  logic               redirect;
  logic               mem_timeout;
  logic [COUNT_W-1:0] stall_cycles;
  logic [COUNT_W-1:0] flush_count;

  modport slave (
    input  id_rs, id_rt, idex_mem_read, idex_rt,
           exmem_zero, exmem_branch_eq, exmem_branch_ne, exmem_jump,
           exmem_mem_access, dmem_ready, perf_clear,
    output pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble, redirect,
           mem_timeout, stall_cycles, flush_count
  );

  modport master (
    output id_rs, id_rt, idex_mem_read, idex_rt,
           exmem_zero, exmem_branch_eq, exmem_branch_ne, exmem_jump,
           exmem_mem_access, dmem_ready, perf_clear,
    input  pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble, redirect,
           mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Ports:
//   clk    rising-edge clock (pipeline registers capture on the falling edge)
//   reset  asynchronous, active-low
//   hz     pipeline_hazard_controller_if.slave (all pipeline-facing signals)
// Same-cycle priority: FAULT > memory hold > taken branch/jump > load-use.
// The FSM only tracks memory waits and the timeout fault; the hold, redirect
// and load-use responses themselves are purely combinational.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0]   TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [COUNT_W-1:0]  stall_q, stall_d;
  logic [COUNT_W-1:0]  flush_q, flush_d;

  logic taken, load_use, mem_hold;
  logic in_fault;
  logic [WAIT_W:0] wait_inc;
  logic last_wait;

  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, redirect;
  logic stall_evt;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  always_comb begin
    taken    = (hz.exmem_branch_eq & hz.exmem_zero)
             | (hz.exmem_branch_ne & ~hz.exmem_zero)
             | hz.exmem_jump;
    // $zero is never really written, so a load to r0 cannot create a hazard.
    load_use = hz.idex_mem_read & (hz.idex_rt != 5'd0)
             & ((hz.idex_rt == hz.id_rs) | (hz.idex_rt == hz.id_rt));
    mem_hold = hz.exmem_mem_access & ~hz.dmem_ready;
    in_fault = (state_q == FAULT);
  end

  // Wait counter holds the number of hold cycles already spent; the cycle
  // whose increment reaches MEM_TIMEOUT is the last one tolerated.
  always_comb begin
    wait_inc  = {1'b0, wait_q} + {{WAIT_W{1'b0}}, 1'b1};
    last_wait = (wait_inc >= TIMEOUT_V);
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (!mem_hold) begin
          // Access completes this cycle; pipeline resumes normally.
          state_d = RUN;
          wait_d  = '0;
        end else if (last_wait) begin
          state_d = FAULT;
          wait_d  = '0;
        end else begin
          wait_d  = wait_inc[WAIT_W-1:0];
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline controls (priority encoded, same cycle)
  // ---------------------------------------------------------------------
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    idex_write   = 1'b0;
    exmem_write  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    redirect     = 1'b0;
    stall_evt    = 1'b0;
    if (!reset) begin
      // Everything quiet while reset is held.
    end else if (in_fault) begin
      memwb_bubble = 1'b1;
    end else if (mem_hold) begin
      // Freeze everything upstream of MEM; MEM/WB drains a bubble.
      memwb_bubble = 1'b1;
      stall_evt    = 1'b1;
    end else if (taken) begin
      // Squash the three younger instructions and load the target.
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      redirect     = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into ID/EX, let the load advance.
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      idex_flush   = 1'b1;
      stall_evt    = 1'b1;
    end else begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Saturating perf counters; clear wins over increment
  // ---------------------------------------------------------------------
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (hz.perf_clear) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (redirect  && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.idex_write   = idex_write;
  assign hz.exmem_write  = exmem_write;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_flush  = exmem_flush;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.redirect     = redirect;
  assign hz.mem_timeout  = in_fault;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;

endmodule
